// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: address-width helper,
// the hard-wired zero register index and packed-bus slice offset helpers.
// Optional same-cycle write forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

    // Register index that always reads as zero and is never written or busy.
    localparam int unsigned ZERO_REG = 0;

    // Address width for a register file holding 'count' registers.
    function automatic int unsigned calc_aw(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Low bit of port 'port' inside a packed address bus.
    function automatic int unsigned addr_lo(input int unsigned port, input int unsigned aw);
        return port * aw;
    endfunction

    // Low bit of port 'port' inside a packed data bus.
    function automatic int unsigned data_lo(input int unsigned port, input int unsigned wl);
        return port * wl;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// Per-register write resolution for the multiport register file: turns the
// packed write-port requests into one write enable and one data word per
// register (registers 1..WordCount-1). When several enabled ports target the
// same register, the highest port index wins. Writes to the zero register and
// to addresses beyond WordCount produce no enable.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned WordLen    = 32,
    parameter int unsigned WordCount  = 32,
    parameter int unsigned WritePorts = 2,
    parameter int unsigned AW         = 5
) (
    input  logic [WritePorts-1:0]           write_en,
    input  logic [WritePorts*AW-1:0]        write_addr,
    input  logic [WritePorts*WordLen-1:0]   write_data,
    output logic [WordCount-1:1]            reg_we,
    output logic [WordCount-1:1][WordLen-1:0] reg_wdata
);

    // Scan ports in ascending order so a later (higher-index) match overrides.
    always_comb begin
        reg_we    = '0;
        reg_wdata = '0;
        for (int unsigned j = 0; j < WritePorts; j++) begin
            for (int unsigned r = ZERO_REG + 1; r < WordCount; r++) begin
                if (write_en[j] && (write_addr[addr_lo(j, AW) +: AW] == AW'(r))) begin
                    reg_we[r]    = 1'b1;
                    reg_wdata[r] = write_data[data_lo(j, WordLen) +: WordLen];
                end
            end
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multiport general-purpose register file with register 0 hard-wired to zero
// and a per-register busy scoreboard for the hazard unit. Reads are
// combinational; writes and busy updates take effect on the rising clock edge.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned WordLen    = 32,
    parameter int unsigned WordCount  = 32,
    parameter int unsigned ReadPorts  = 2,
    parameter int unsigned WritePorts = 2,
    localparam int unsigned AW        = calc_aw(WordCount)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ReadPorts*AW-1:0]       readRegister,
    output logic [ReadPorts*WordLen-1:0]  readData,
    output logic [ReadPorts-1:0]          readBusy,
    input  logic [WritePorts-1:0]         regWrite,
    input  logic [WritePorts*AW-1:0]      writeRegister,
    input  logic [WritePorts*WordLen-1:0] writeData,
    input  logic                          reserve,
    input  logic [AW-1:0]                 reserveRegister
);

    // Storage exists only for registers 1..WordCount-1; register 0 is implicit.
    logic [WordCount-1:1][WordLen-1:0] mem;
    logic [WordCount-1:1]              busy;

    logic [WordCount-1:1]              reg_we;
    logic [WordCount-1:1][WordLen-1:0] reg_wdata;

    regfile_write_arbiter #(
        .WordLen    (WordLen),
        .WordCount  (WordCount),
        .WritePorts (WritePorts),
        .AW         (AW)
    ) u_write_arbiter (
        .write_en   (regWrite),
        .write_addr (writeRegister),
        .write_data (writeData),
        .reg_we     (reg_we),
        .reg_wdata  (reg_wdata)
    );

    // Register storage and busy scoreboard; a same-cycle reserve beats a write clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            for (int unsigned r = ZERO_REG + 1; r < WordCount; r++) begin
                if (reg_we[r]) begin
                    mem[r] <= reg_wdata[r];
                end
                if (reserve && (reserveRegister == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (reg_we[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports; zero and out-of-range addresses match nothing.
    always_comb begin
        readData = '0;
        readBusy = '0;
        for (int unsigned i = 0; i < ReadPorts; i++) begin
            for (int unsigned r = ZERO_REG + 1; r < WordCount; r++) begin
                if (readRegister[addr_lo(i, AW) +: AW] == AW'(r)) begin
`ifdef REGFILE_BYPASS_EN
                    if (!rst && reg_we[r]) begin
                        readData[data_lo(i, WordLen) +: WordLen] = reg_wdata[r];
                        readBusy[i] = 1'b0;
                    end else begin
                        readData[data_lo(i, WordLen) +: WordLen] = mem[r];
                        readBusy[i] = busy[r];
                    end
`else
                    readData[data_lo(i, WordLen) +: WordLen] = mem[r];
                    readBusy[i] = busy[r];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file: a default-sized
// instance (32x32, 2 read, 2 write ports) and a small instance
// (16-bit x 8, 3 read, 1 write port). Bypass expectations follow REGFILE_BYPASS_EN.
module tb_multiport_register_file;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance: AW = 5
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv;
    logic [4:0]  rsv_addr;

    // Small instance: AW = 3
    logic [8:0]  p_rd_addr;
    logic [47:0] p_rd_data;
    logic [2:0]  p_rd_busy;
    logic [0:0]  p_wr_en;
    logic [2:0]  p_wr_addr;
    logic [15:0] p_wr_data;
    logic        p_rsv;
    logic [2:0]  p_rsv_addr;

    int checks   = 0;
    int failures = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    multiport_register_file dut (
        .clk             (clk),
        .rst             (rst),
        .readRegister    (rd_addr),
        .readData        (rd_data),
        .readBusy        (rd_busy),
        .regWrite        (wr_en),
        .writeRegister   (wr_addr),
        .writeData       (wr_data),
        .reserve         (rsv),
        .reserveRegister (rsv_addr)
    );

    multiport_register_file #(
        .WordLen    (16),
        .WordCount  (8),
        .ReadPorts  (3),
        .WritePorts (1)
    ) dut_small (
        .clk             (clk),
        .rst             (rst),
        .readRegister    (p_rd_addr),
        .readData        (p_rd_data),
        .readBusy        (p_rd_busy),
        .regWrite        (p_wr_en),
        .writeRegister   (p_wr_addr),
        .writeData       (p_wr_data),
        .reserve         (p_rsv),
        .reserveRegister (p_rsv_addr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rsv       = 1'b0;
        rsv_addr  = '0;
        p_wr_en   = '0;
        p_wr_addr = '0;
        p_wr_data = '0;
        p_rsv     = 1'b0;
        p_rsv_addr = '0;
    endtask

    task automatic drive_write(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_en[port]          = 1'b1;
        wr_addr[port*5 +: 5] = a;
        wr_data[port*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rd_addr = {5'd31, 5'd5};
        p_rd_addr = '0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=%h", rd_data, 64'h0);
        end
        checks++;
        if (rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=%b", rd_busy, 2'b00);
        end
        drive_write(0, 5'd5, 32'hDEADBEEF);
        rsv = 1'b1;
        rsv_addr = 5'd6;
        step();
        idle();
        rd_addr = {5'd6, 5'd5};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL pre_reset_write got=%h exp=%h", rd_data[31:0], 32'hDEADBEEF);
        end
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_busy got=%b exp=%b", rd_busy[1], 1'b1);
        end
        rst = 1'b1;
        drive_write(1, 5'd5, 32'h00000001);
        rsv = 1'b1;
        rsv_addr = 5'd7;
        step();
        rst = 1'b0;
        idle();
        rd_addr = {5'd7, 5'd5};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL midrun_reset_data got=%h exp=%h", rd_data[31:0], 32'h0);
        end
        checks++;
        if (rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL midrun_reset_busy got=%b exp=%b", rd_busy, 2'b00);
        end
        rd_addr = {5'd7, 5'd6};
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL reset_clears_busy got=%b exp=%b", rd_busy, 2'b00);
        end
    endtask

    task automatic test_zero_reg();
        drive_write(0, 5'd0, 32'h00001234);
        rsv = 1'b1;
        rsv_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        step();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL zero_reg_data got=%h exp=%h", rd_data[31:0], 32'h0);
        end
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg_busy got=%b exp=%b", rd_busy[0], 1'b0);
        end
    endtask

    task automatic test_conflict();
        drive_write(0, 5'd7, 32'h00000011);
        drive_write(1, 5'd7, 32'h00000022);
        step();
        idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h00000022) begin
            failures++;
            $display("FAIL conflict_high_wins got=%h exp=%h", rd_data[31:0], 32'h00000022);
        end
        drive_write(0, 5'd10, 32'h000000AA);
        drive_write(1, 5'd11, 32'h000000BB);
        step();
        idle();
        rd_addr = {5'd11, 5'd10};
        #1;
        checks++;
        if (rd_data !== {32'h000000BB, 32'h000000AA}) begin
            failures++;
            $display("FAIL dual_write got=%h exp=%h", rd_data, {32'h000000BB, 32'h000000AA});
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd0, 5'd3};
        rsv = 1'b1;
        rsv_addr = 5'd3;
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL reserve_sets_busy got=%b exp=%b", rd_busy[0], 1'b1);
        end
        drive_write(0, 5'd3, 32'h00000055);
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h00000055) begin
            failures++;
            $display("FAIL write_clears_busy got=%b/%h exp=%b/%h", rd_busy[0], rd_data[31:0], 1'b0, 32'h00000055);
        end
        drive_write(1, 5'd3, 32'h00000066);
        rsv = 1'b1;
        rsv_addr = 5'd3;
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h00000066) begin
            failures++;
            $display("FAIL reserve_and_write got=%b/%h exp=%b/%h", rd_busy[0], rd_data[31:0], 1'b1, 32'h00000066);
        end
        drive_write(0, 5'd3, 32'h00000077);
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h00000077) begin
            failures++;
            $display("FAIL second_clear got=%b/%h exp=%b/%h", rd_busy[0], rd_data[31:0], 1'b0, 32'h00000077);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        drive_write(0, 5'd9, 32'h00001111);
        rsv = 1'b1;
        rsv_addr = 5'd9;
        step();
        idle();
        rd_addr = {5'd0, 5'd9};
        drive_write(1, 5'd9, 32'h0000CAFE);
        #1;
        exp_d = BYPASS ? 32'h0000CAFE : 32'h00001111;
        exp_b = BYPASS ? 1'b0 : 1'b1;
        checks++;
        if (rd_data[31:0] !== exp_d) begin
            failures++;
            $display("FAIL same_cycle_data got=%h exp=%h", rd_data[31:0], exp_d);
        end
        checks++;
        if (rd_busy[0] !== exp_b) begin
            failures++;
            $display("FAIL same_cycle_busy got=%b exp=%b", rd_busy[0], exp_b);
        end
        step();
        idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0000CAFE || rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL next_cycle_data got=%h/%b exp=%h/%b", rd_data[31:0], rd_busy[0], 32'h0000CAFE, 1'b0);
        end
    endtask

    task automatic test_param();
        logic [47:0] exp;
        for (int k = 1; k < 8; k++) begin
            p_wr_en   = 1'b1;
            p_wr_addr = 3'(k);
            p_wr_data = 16'hA000 + 16'(k * 16'h0111);
            step();
        end
        idle();
        p_rd_addr = {3'd7, 3'd4, 3'd1};
        #1;
        exp = {16'hA777, 16'hA444, 16'hA111};
        checks++;
        if (p_rd_data !== exp) begin
            failures++;
            $display("FAIL small_read_147 got=%h exp=%h", p_rd_data, exp);
        end
        p_rd_addr = {3'd6, 3'd5, 3'd2};
        #1;
        exp = {16'hA666, 16'hA555, 16'hA222};
        checks++;
        if (p_rd_data !== exp) begin
            failures++;
            $display("FAIL small_read_256 got=%h exp=%h", p_rd_data, exp);
        end
        p_rd_addr = {3'd7, 3'd0, 3'd3};
        #1;
        exp = {16'hA777, 16'h0000, 16'hA333};
        checks++;
        if (p_rd_data !== exp || p_rd_busy !== 3'b000) begin
            failures++;
            $display("FAIL small_read_307 got=%h/%b exp=%h/%b", p_rd_data, p_rd_busy, exp, 3'b000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_bypass();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the pipelined MIPS-style datapath: configurable word width, depth, read-port count and write-port count, with register 0 hard-wired to zero. Holds a per-register busy scoreboard so the hazard unit can stall on pending writebacks, and optionally forwards same-cycle write data to the read ports. Sits between decode (reads, reserves) and writeback (writes).

## Interface
Parameters:
- WordLen, 32, bits per register
- WordCount, 32, number of registers (≥2); AW = ceil(log2(WordCount))
- ReadPorts, 2, number of read ports (≥1)
- WritePorts, 2, number of write ports (≥1)

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- readRegister  input  ReadPorts*AW  packed read addresses, port i at [i*AW +: AW]
- readData  output  ReadPorts*WordLen  packed read data, port i at [i*WordLen +: WordLen]
- readBusy  output  ReadPorts  busy bit of the register addressed by port i
- regWrite  input  WritePorts  per-port write enable
- writeRegister  input  WritePorts*AW  packed write addresses
- writeData  input  WritePorts*WordLen  packed write data
- reserve  input  1  mark reserveRegister busy (decode issued a producer)
- reserveRegister  input  AW  register to mark busy

## Operation
- Storage: WordCount × WordLen registers, busy vector of WordCount bits.
- Reads: combinational; readData[i] = reg[readRegister[i]]; address 0 always returns 0; address ≥ WordCount returns 0 and readBusy 0.
- Writes: on posedge, each port j with regWrite[j]=1 and writeRegister[j]≠0 writes writeData[j]. Writes to register 0 ignored.
- Write conflict: several enabled ports on the same address → highest port index wins.
- Busy: reserve=1 with reserveRegister≠0 sets busy; any enabled write to a register clears its busy bit. Reserve and write on the same register in the same cycle → busy remains 1 (new producer supersedes). Register 0 never busy.
- Reset (rst=1 at posedge): all registers to 0, all busy bits to 0; writes and reserves in that cycle ignored. Applies equally mid-operation.

## Timing
- Read latency 0 (combinational from address and state).
- Write visible to reads the cycle after the write edge (without bypass).
- Busy set/clear visible the cycle after the edge.
- After reset edge: readData = 0, readBusy = 0 for every port/address.
- No handshakes; every enabled request is accepted every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: readData[i] returns writeData of the highest-index enabled write port whose writeRegister matches readRegister[i] (≠0) in the same cycle, and readBusy[i] is 0 for that read; creates a combinational path writeData → readData. Suppressed while rst=1.
- Undefined: reads return stored contents only; same-cycle writes visible next cycle.

## Structure
- Shared package regfile_pkg: function for AW, zero-register constant, packed-slice helper functions.
- One sub-module: regfile_write_arbiter — per-register resolution of write-enable/data across write ports (highest index wins), instanced once, also feeding the bypass match logic.

## Test plan
- Reset: write 0xDEADBEEF to r5, then rst=1 one cycle → reading r5 gives 0, readBusy 0.
- Zero register: regWrite[0]=1, writeRegister=0, writeData=0x1234 → read r0 next cycle = 0; reserve r0 → readBusy stays 0.
- Write conflict: ports 0 and 1 both write r7 with 0x11 and 0x22 → r7 = 0x22 next cycle.
- Scoreboard: reserve r3 → readBusy=1 next cycle; write r3=0x55 → readBusy=0, data 0x55; reserve r3 and write r3 same cycle → readBusy stays 1, data updated.
- Bypass (with REGFILE_BYPASS_EN): write r9=0xCAFE while reading r9 same cycle → readData=0xCAFE, readBusy=0; without the macro → old value that cycle, 0xCAFE next.
- Parametrisation: WordLen=16, WordCount=8, ReadPorts=3, WritePorts=1 → all three ports read independent registers correctly after writes to r1..r7.
